// File: rtl/moxie_wb_master_if.sv
// ============================================================================
// Module : moxie_wb_master_if
// Brief  : Wishbone classic bus bundle between moxie_wb_master and the fabric.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface moxie_wb_master_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32
) ();
    localparam int SEL_W = DATA_W / 8;

    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat_w;
    logic [DATA_W-1:0] dat_r;
    logic [SEL_W-1:0]  sel;
    logic              we;
    logic              cyc;
    logic              stb;
    logic              ack;
    logic              err;

    modport master (
        output adr, dat_w, sel, we, cyc, stb,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb,
        output dat_r, ack, err
    );
endinterface

`default_nettype wire

// File: rtl/moxie_wb_master.sv
// ============================================================================
// Module : moxie_wb_master
// Brief  : Registered bridge from the MoxieLite strobe/wait bus to a Wishbone
//          classic master, with error termination and a bus-timeout watchdog.
// Config : define MOXIE_WB_POSTED_WRITE_EN for the 1-entry posted-write buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module moxie_wb_master #(
    parameter int                       DATA_W   = 16,
    parameter int                       ADDR_W   = 32,
    parameter int                       TIMEOUT  = 255,
    parameter logic [DATA_W-1:0]        ERR_DATA = '1
) (
    input  wire logic                                    clk_i,
    input  wire logic                                    rst_i,
    input  wire logic [ADDR_W-$clog2(DATA_W/8)-1:0]      cpu_addr_i,
    input  wire logic [DATA_W-1:0]                       cpu_dout_i,
    output logic      [DATA_W-1:0]                       cpu_din_o,
    input  wire logic                                    cpu_rd_n_i,
    input  wire logic                                    cpu_wr_n_i,
    input  wire logic [DATA_W/8-1:0]                     cpu_be_n_i,
    output logic                                         cpu_wait_n_o,
    moxie_wb_master_if.master                            wb,
    output logic                                         bus_err_o,
    output logic      [ADDR_W-1:0]                       err_adr_o
);

    localparam int c_SEL_W = DATA_W / 8;
    localparam int c_LSB   = $clog2(c_SEL_W);
    localparam int c_TMO_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX = {c_TMO_W{1'b1}};

`ifdef MOXIE_WB_POSTED_WRITE_EN
    localparam bit c_POSTED = 1'b1;
`else
    localparam bit c_POSTED = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_adr;
    logic [DATA_W-1:0]   r_dat;
    logic [c_SEL_W-1:0]  r_sel;
    logic                r_we;
    logic                r_cyc;
    logic [DATA_W-1:0]   r_din;
    logic                r_bus_err;
    logic [ADDR_W-1:0]   r_err_adr;
    logic [c_TMO_W-1:0]  r_tmo_cnt;
    logic                r_posted;

    logic                w_req;
    logic                w_is_wr;
    logic [ADDR_W-1:0]   w_cpu_badr;
    logic                w_tmo_hit;
    logic                w_term;
    logic                w_fault;
    logic                w_wait_n;

    // Both strobes low is resolved as a write.
    assign w_req      = !cpu_rd_n_i || !cpu_wr_n_i;
    assign w_is_wr    = !cpu_wr_n_i;
    assign w_cpu_badr = {cpu_addr_i, {c_LSB{1'b0}}};

    // The counter holds the number of completed BUS cycles, so the current
    // cycle is the TIMEOUT-th one when it reads TIMEOUT-1.
    generate
        if (TIMEOUT == 0) begin : g_wdog_off
            assign w_tmo_hit = 1'b0;
        end else begin : g_wdog_on
            localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
            assign w_tmo_hit = (r_state == S_BUS) && (r_tmo_cnt == c_TMO_LAST);
        end
    endgenerate

    // err beats ack; a real termination beats a coincident timeout.
    assign w_term  = wb.ack || wb.err || w_tmo_hit;
    assign w_fault = wb.err || (w_tmo_hit && !wb.ack);

    always_comb begin
        w_wait_n = 1'b1;
        case (r_state)
            S_IDLE:  if (w_req && !(c_POSTED && w_is_wr)) w_wait_n = 1'b0;
            S_BUS:   if (!r_posted || w_req)              w_wait_n = 1'b0;
            S_DONE:  if (r_posted && w_req)               w_wait_n = 1'b0;
            default: w_wait_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_we      <= 1'b0;
            r_cyc     <= 1'b0;
            r_din     <= '0;
            r_bus_err <= 1'b0;
            r_err_adr <= '0;
            r_tmo_cnt <= '0;
            r_posted  <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_adr     <= w_cpu_badr;
                        r_dat     <= cpu_dout_i;
                        r_sel     <= w_is_wr ? ~cpu_be_n_i : {c_SEL_W{1'b1}};
                        r_we      <= w_is_wr;
                        r_cyc     <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_posted  <= c_POSTED && w_is_wr;
                        r_state   <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (r_tmo_cnt != c_TMO_MAX) begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                    if (w_term) begin
                        r_cyc   <= 1'b0;
                        r_state <= S_DONE;
                        if (w_fault) begin
                            r_bus_err <= 1'b1;
                            r_err_adr <= r_adr;
                            if (!r_we) r_din <= ERR_DATA;
                        end else if (!r_we) begin
                            r_din <= wb.dat_r;
                        end
                    end
                end
                S_DONE: begin
                    // A request still held here is the one just served.
                    r_posted <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wb.adr       = r_adr;
    assign wb.dat_w     = r_dat;
    assign wb.sel       = r_sel;
    assign wb.we        = r_we;
    assign wb.cyc       = r_cyc;
    assign wb.stb       = r_cyc;
    assign cpu_din_o    = r_din;
    assign cpu_wait_n_o = w_wait_n;
    assign bus_err_o    = r_bus_err;
    assign err_adr_o    = r_err_adr;

endmodule

`default_nettype wire
